fib_reverse_stepper: RTL

Walks a Fibonacci sequence backwards from a loaded adjacent pair (F(n), F(n+1)) down to (F(0), F(1)). Each step computes the earlier term F(n-1) = F(n+1) - F(n) with a bit-serial ripple subtractor, one bit per clock, LSB first. It emits each recovered term on a valid strobe. It is the inverse-direction companion of the forward adder-based generator and is used to check and replay generated sequences.

---
 rtl/fib_reverse_stepper.sv | 126 ++++++++++++
 1 files changed

// File: rtl/fib_reverse_stepper.sv
// fib_reverse_stepper
//   Walks a Fibonacci sequence backwards from a loaded adjacent pair
//   (F(n), F(n+1)) down to F(0). Each earlier term F(k-1) = F(k+1) - F(k)
//   is formed by a bit-serial ripple subtractor, one bit per clock, LSB first.
//   Each recovered term is presented on term_out with a term_valid strobe.
//
// Ports
//   clk        : rising-edge clock
//   reset      : asynchronous, active-high clear of all state
//   start      : load request, sampled only in IDLE
//   prev_in    : F(n), the lower term of the starting pair
//   curr_in    : F(n+1), the upper term of the starting pair
//   busy       : walk in progress (stays high through the done cycle)
//   term_valid : one-cycle strobe qualifying term_out
//   term_out   : last recovered term; held between strobes
//   step_count : terms emitted since the last start (saturating)
//   done       : one-cycle pulse at the end of a walk
//   error      : sticky borrow flag (upper < lower); cleared by the next start
module fib_reverse_stepper #(
  parameter int WIDTH   = 64,
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   prev_in,
  input  logic [WIDTH-1:0]   curr_in,
  output logic               busy,
  output logic               term_valid,
  output logic [WIDTH-1:0]   term_out,
  output logic [COUNT_W-1:0] step_count,
  output logic               done,
  output logic               error
);

  localparam int BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SUB, FIN, DONE} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] a, b, d;   // a = lower term, b = upper term, d = b - a
  logic             bw;        // running borrow
  logic [BCW-1:0]   bitcnt;
  logic             dbit, bw_n;

  // One full-subtractor slice on the current LSBs of b and a.
  always_comb begin
    dbit = b[0] ^ a[0] ^ bw;
    bw_n = (~b[0] & a[0]) | (~(b[0] ^ a[0]) & bw);
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (start) state_n = (prev_in == '0) ? DONE : SUB;
      SUB:  if (bitcnt == LAST_BIT) state_n = FIN;
      // A borrow ends the walk with an error; a zero difference is F(0).
      FIN:  state_n = (bw || d == '0) ? DONE : SUB;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a          <= '0;
      b          <= '0;
      d          <= '0;
      bw         <= 1'b0;
      bitcnt     <= '0;
      busy       <= 1'b0;
      term_valid <= 1'b0;
      term_out   <= '0;
      step_count <= '0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      term_valid <= 1'b0;
      done       <= 1'b0;
      // busy falls the cycle after the done pulse; a start accepted on that
      // same edge re-asserts it below.
      if (done) busy <= 1'b0;
      case (state)
        IDLE: if (start) begin
          a          <= prev_in;
          b          <= curr_in;
          step_count <= '0;
          error      <= 1'b0;
          bitcnt     <= '0;
          bw         <= 1'b0;
          busy       <= 1'b1;
        end
        SUB: begin
          d      <= {dbit, d[WIDTH-1:1]};
          // Rotating (not shifting) restores a and b after WIDTH bits.
          a      <= {a[0], a[WIDTH-1:1]};
          b      <= {b[0], b[WIDTH-1:1]};
          bw     <= bw_n;
          bitcnt <= (bitcnt == LAST_BIT) ? '0 : bitcnt + 1'b1;
        end
        FIN: begin
          bw <= 1'b0;
          if (bw) begin
            error <= 1'b1;
          end else begin
            term_valid <= 1'b1;
            term_out   <= d;
            if (step_count != {COUNT_W{1'b1}}) step_count <= step_count + 1'b1;
            // Slide the window down one term: (a, b) <- (d, a).
            b <= a;
            a <= d;
          end
        end
        DONE: done <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule
